// File: rtl/load_store_unit.sv
// Load/store engine between the ALU and a req/ack data memory. Stalls the core while an
// access is in flight, then returns extended load data or a fault/timeout status.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        timeout_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct_q, funct_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        timeout_q, timeout_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic        illegal, misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Request decode from the live ALU inputs
    always_comb begin
        if (mem_we_i) begin
            illegal = funct_i[2] | (funct_i[1:0] == 2'b11);
        end else begin
            illegal = (funct_i == 3'b011) | (funct_i[2:1] == 2'b11);
        end
        misaligned = ((funct_i[1:0] == 2'b01) & addr_i[0]) |
                     ((funct_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
        case (funct_i[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << addr_i[1:0];
                wdata_dec = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_dec    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{store_data_i[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = store_data_i;
            end
        endcase
    end

    // Load lane extraction from the returned word
    always_comb begin
        lane = dmem_rdata_i >> {off_q, 3'b000};
        case (funct_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct_d     = funct_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        timeout_d   = timeout_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        unique case (state_q)
            StIdle: begin
                if (mem_en_i) begin
                    fault_d   = 1'b0;
                    timeout_d = 1'b0;
                    if (illegal || misaligned) begin
                        fault_d     = 1'b1;
                        load_data_d = 32'h0;
                        done_d      = 1'b1;
                        state_d     = StDone;
                    end else begin
                        addr_d  = {addr_i[31:2], 2'b00};
                        we_d    = mem_we_i;
                        be_d    = be_dec;
                        wdata_d = wdata_dec;
                        funct_d = funct_i;
                        off_d   = addr_i[1:0];
                        cnt_d   = 8'h0;
                        req_d   = 1'b1;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                // An ack in the final allowed cycle beats the timeout
                if (dmem_ack_i) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        load_data_d = load_ext;
                    end
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    req_d       = 1'b0;
                    timeout_d   = 1'b1;
                    load_data_d = 32'h0;
                    done_d      = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 8'h0;
            funct_q     <= 3'h0;
            off_q       <= 2'h0;
            load_data_q <= 32'h0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            timeout_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct_q     <= funct_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            timeout_q   <= timeout_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    assign stall_o      = ((state_q == StIdle) & mem_en_i) | (state_q == StBusy);
    assign load_data_o  = load_data_q;
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign timeout_o    = timeout_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with MAX_WAIT=4; drives on negedge, samples 1ns later.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  funct = 3'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic        timeout;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    load_store_unit #(.MAX_WAIT(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_en_i     (mem_en),
        .mem_we_i     (mem_we),
        .funct_i      (funct),
        .addr_i       (addr),
        .store_data_i (store_data),
        .stall_o      (stall),
        .load_data_o  (load_data),
        .done_o       (done),
        .fault_o      (fault),
        .timeout_o    (timeout),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_be_o    (dmem_be),
        .dmem_ack_i   (dmem_ack),
        .dmem_rdata_i (dmem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int          r_done_cyc, r_stall, r_req;
    logic [31:0] r_addr, r_wdata, r_ld;
    logic [3:0]  r_be;
    logic        r_we, r_fault, r_to, r_stable;

    // ack_at: BUSY cycle (1-based) on which to ack; 0 means never ack
    task automatic access(input logic we, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input int ack_at, input logic [31:0] rd);
        r_done_cyc = -1; r_stall = 0; r_req = 0; r_stable = 1'b1;
        r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0; r_we = 1'b0;
        r_fault = 1'b0; r_to = 1'b0; r_ld = 32'h0;
        @(negedge clk);
        mem_en = 1'b1; mem_we = we; funct = f; addr = a; store_data = sd;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 1) mem_en = 1'b0;
            #1;
            if (stall) r_stall++;
            if (done) begin
                r_done_cyc = cyc; r_fault = fault; r_to = timeout; r_ld = load_data;
                break;
            end
            if (dmem_req) begin
                r_req++;
                if (r_req == 1) begin
                    r_addr = dmem_addr; r_wdata = dmem_wdata; r_be = dmem_be; r_we = dmem_we;
                end else if (dmem_addr !== r_addr || dmem_wdata !== r_wdata ||
                             dmem_be !== r_be || dmem_we !== r_we) begin
                    r_stable = 1'b0;
                end
            end
            dmem_ack   = dmem_req && (r_req == ack_at);
            dmem_rdata = rd;
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        mem_en   = 1'b0;
    endtask

    int seen;

    initial begin
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_ld", load_data, 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        check("lw_addr", r_addr, 32'h100);
        check("lw_be", {28'h0, r_be}, 32'hF);
        check("lw_we", {31'h0, r_we}, 32'h0);
        check("lw_done_cyc", r_done_cyc, 2);
        check("lw_data", r_ld, 32'hDEADBEEF);
        check("lw_stall", r_stall, 2);
        check("lw_flags", {30'h0, r_fault, r_to}, 32'h0);

        access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80AA55CC);
        check("lb_be", {28'h0, r_be}, 32'h8);
        check("lb_data", r_ld, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80AA55CC);
        check("lbu_data", r_ld, 32'h00000080);

        access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'hFFFFFFFF);
        check("sh_addr", r_addr, 32'h200);
        check("sh_be", {28'h0, r_be}, 32'hC);
        check("sh_wdata", r_wdata, 32'hABCDABCD);
        check("sh_we", {31'h0, r_we}, 32'h1);
        check("sh_ld_kept", r_ld, 32'h00000080);

        access(1'b1, 3'b000, 32'h101, 32'h000000A5, 1, 32'h0);
        check("sb_be", {28'h0, r_be}, 32'h2);
        check("sb_wdata", r_wdata, 32'hA5A5A5A5);

        access(1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80017FFF);
        check("lh_be", {28'h0, r_be}, 32'hC);
        check("lh_data", r_ld, 32'hFFFF8001);
        access(1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h00009ABC);
        check("lhu_data", r_ld, 32'h00009ABC);

        access(1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h11111111);
        check("to_req_cycles", r_req, 4);
        check("to_done_cyc", r_done_cyc, 5);
        check("to_flag", {31'h0, r_to}, 32'h1);
        check("to_ld", r_ld, 32'h0);
        check("to_stable", {31'h0, r_stable}, 32'h1);

        access(1'b0, 3'b010, 32'h108, 32'h0, 4, 32'h13572468);
        check("late_ack_done_cyc", r_done_cyc, 5);
        check("late_ack_to", {31'h0, r_to}, 32'h0);
        check("late_ack_data", r_ld, 32'h13572468);

        access(1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h0);
        check("mis_req", r_req, 0);
        check("mis_done_cyc", r_done_cyc, 1);
        check("mis_fault", {31'h0, r_fault}, 32'h1);
        check("mis_ld", r_ld, 32'h0);
        access(1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
        check("ill_req", r_req, 0);
        check("ill_fault", {31'h0, r_fault}, 32'h1);
        access(1'b1, 3'b010, 32'h102, 32'h55555555, 1, 32'h0);
        check("sw_mis_fault", {31'h0, r_fault}, 32'h1);
        check("sw_mis_req", r_req, 0);

        access(1'b0, 3'b010, 32'h10C, 32'h0, 1, 32'hCAFEF00D);
        check("b2b_fault_clr", {31'h0, r_fault}, 32'h0);
        check("b2b_data", r_ld, 32'hCAFEF00D);

        // Reset while BUSY, then a stray ack after release
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; funct = 3'b010; addr = 32'h300;
        @(negedge clk);
        mem_en = 1'b0;
        #1;
        check("rb_busy_req", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rb_req", {31'h0, dmem_req}, 32'h0);
        check("rb_stall", {31'h0, stall}, 32'h0);
        check("rb_addr", dmem_addr, 32'h0);
        check("rb_be", {28'h0, dmem_be}, 32'h0);
        check("rb_ld", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (done || stall || dmem_req) seen++;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        check("rb_ack_ignored", seen, 0);
        check("rb_ld_after", load_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store engine that sits directly downstream of the ALU in the RV32I core. It consumes the ALU's computed effective address, plus funct3 and the rs2 store data. It drives a request/acknowledge data-memory port with word-aligned address and byte enables, returns sign- or zero-extended load data to writeback, and stalls the otherwise single-cycle datapath until the access completes, faults or times out.

## Interface
- MAX_WAIT, default 255: BUSY cycles without `dmem_ack` before timeout; range 1..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_en  in  1  current instruction is a load/store
- mem_we  in  1  1 = store, 0 = load
- funct  in  3  funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- stall  out  1  freeze PC and register-file write
- load_data  out  32  extended load result
- done  out  1  one-cycle completion pulse
- fault  out  1  misaligned or illegal funct; valid with done
- timeout  out  1  no ack within MAX_WAIT; valid with done
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write strobe
- dmem_addr  out  32  {addr[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  memory accepted/returned data this cycle
- dmem_rdata  in  32  read word, valid with ack

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Accept when `mem_en`=1. Illegal funct means load 011/110/111 or store ≥011. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Illegal or misaligned: no memory request. Go to DONE with fault=1 and load_data=0.
  - Otherwise latch dmem_addr, dmem_we, dmem_be and dmem_wdata, clear the wait counter, and go to BUSY.
- Byte enables and store data:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{store_data[15:0]}}.
  - SW: be = 4'b1111, wdata = store_data.
  - Loads use the same be pattern; dmem_we=0.
- BUSY: dmem_req=1. The counter increments each cycle without ack.
  - `dmem_ack`=1: for a load, extract the lane (rdata >> 8·addr[1:0]), then sign-extend (LB/LH) or zero-extend (LBU/LHU) into load_data. Go to DONE.
  - Counter reaches MAX_WAIT without ack: drop the request, set timeout=1 and load_data=0, go to DONE.
  - Ack in the same cycle the counter reaches MAX_WAIT: ack wins, timeout=0.
- DONE: done=1 for exactly one cycle, stall=0, return to IDLE. mem_en is ignored here, because it still belongs to the completing instruction.
- A completed store leaves load_data unchanged. fault and timeout clear on the next accepted access.
- stall = (IDLE & mem_en) | BUSY. This is combinational; all other outputs are registered.

## Timing
- Reset (async, any state): state IDLE. stall, load_data, done, fault, timeout, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be all go to 0 immediately. An in-flight request is abandoned, and a later ack is ignored in IDLE.
- Aligned access, ack in first BUSY cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUSY, req=1, ack.
  - cycle 2: DONE, done=1, stall=0, load_data valid.
- Each extra wait cycle adds one cycle.
- Fault: cycle 0 IDLE (stall=1), cycle 1 DONE (done=1, fault=1). No dmem_req.
- Timeout: done asserts MAX_WAIT+1 cycles after cycle 0.
- dmem_addr, dmem_wdata, dmem_be and dmem_we stay stable for the whole time dmem_req is high.
- Back-to-back accesses: the next mem_en is accepted in the IDLE cycle right after DONE.

## Test plan
- LW addr=0x100, rdata=0xDEADBEEF, ack in first BUSY cycle → dmem_addr=0x100, be=1111, done at cycle 2, load_data=0xDEADBEEF, stall high for exactly 2 cycles.
- LB addr=0x103 and LBU addr=0x103, rdata=0x80AA55CC → be=1000; LB load_data=0xFFFFFF80, LBU load_data=0x00000080.
- SH addr=0x202, store_data=0x1234ABCD → dmem_addr=0x200, be=1100, wdata=0xABCDABCD, dmem_we=1; load_data unchanged after done.
- LW addr=0x101 and funct=011 load → no dmem_req, done with fault=1 at cycle 1, load_data=0.
- MAX_WAIT=4, no ack → req high for 4 cycles, then done with timeout=1. A second run with ack on the 4th BUSY cycle → timeout=0 and valid data.
- rst_n low during BUSY with ack arriving 2 cycles after reset release → all outputs 0 immediately, FSM in IDLE, late ack produces no done.
